// File: rtl/sm_pkg.sv
// Shared types and sign-magnitude helpers for the min/max stream block.
package sm_pkg;

  localparam int unsigned SM_MAX_W = 64;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Operands are zero-extended to SM_MAX_W; n is the real sample width.
  function automatic logic sm_sign(input logic [SM_MAX_W-1:0] x, input int unsigned n);
    return 1'(x >> (n - 1));
  endfunction

  function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] x, input int unsigned n);
    return x & ~({SM_MAX_W{1'b1}} << (n - 1));
  endfunction

  function automatic logic sm_is_zero(input logic [SM_MAX_W-1:0] x, input int unsigned n);
    return sm_mag(x, n) == '0;
  endfunction

endpackage

// File: rtl/sm_compare.sv
// Combinational sign-magnitude comparator; -0 is treated as +0.
module sm_compare
  import sm_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_gt,
  output logic         o_eq
);

  localparam int unsigned MW = N - 1;

  logic [MW-1:0] w_mag_a;
  logic [MW-1:0] w_mag_b;
  logic          w_neg_a;
  logic          w_neg_b;

  // Normalised sign: a zero magnitude never counts as negative.
  always_comb begin
    w_mag_a = MW'(sm_mag(SM_MAX_W'(i_a), N));
    w_mag_b = MW'(sm_mag(SM_MAX_W'(i_b), N));
    w_neg_a = sm_sign(SM_MAX_W'(i_a), N) && !sm_is_zero(SM_MAX_W'(i_a), N);
    w_neg_b = sm_sign(SM_MAX_W'(i_b), N) && !sm_is_zero(SM_MAX_W'(i_b), N);
  end

  always_comb begin
    o_eq = (w_neg_a == w_neg_b) && (w_mag_a == w_mag_b);
    if (w_neg_a != w_neg_b) begin
      o_gt = w_neg_b;
    end else if (!w_neg_a) begin
      o_gt = w_mag_a > w_mag_b;
    end else begin
      o_gt = w_mag_a < w_mag_b;
    end
  end

endmodule

// File: rtl/sm_minmax_stream.sv
// Framed stream reducer: returns the max or min sign-magnitude sample and its index.
module sm_minmax_stream
  import sm_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned IDX_W  = $clog2(MAX_LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode,
  input  logic             i_valid,
  input  logic [N-1:0]     i_data,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_result,
  output logic [IDX_W-1:0] o_index,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_cand;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_ovf;

  logic w_accept;
  logic w_gt;
  logic w_eq;
  logic w_better;
  logic w_in_range;

  sm_compare #(.N(N)) u_cmp (
    .i_a  (i_data),
    .i_b  (r_cand),
    .o_gt (w_gt),
    .o_eq (w_eq)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_in_range = r_cnt < CNT_MAX;
    w_better   = (r_mode == MODE_MIN) ? (!w_gt && !w_eq) : w_gt;
    case (r_state)
      IDLE: begin
        w_accept = i_valid;
        if (i_valid) w_next = i_last ? DONE : ACC;
      end
      ACC: begin
        w_accept = i_valid;
        if (i_valid && i_last) w_next = DONE;
      end
      DONE: begin
        if (i_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Candidate tracking; the counter only advances while in range, so it saturates at MAX_LEN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cand <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_mode <= MODE_MAX;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_cand <= i_data;
        r_idx  <= '0;
        r_cnt  <= CNT_W'(1);
        r_mode <= i_mode;
        r_ovf  <= 1'b0;
      end else if (w_in_range) begin
        if (w_better) begin
          r_cand <= i_data;
          r_idx  <= r_cnt[IDX_W-1:0];
        end
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_ready  = (r_state != DONE);
  assign o_valid  = (r_state == DONE);
  assign o_busy   = (r_state != IDLE);
  assign o_result = r_cand;
  assign o_index  = r_idx;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_sm_minmax_stream.sv
// Randomised and directed bench for sm_minmax_stream against an integer reference model.
module tb_sm_minmax_stream;

  localparam int unsigned N       = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned IDX_W   = 4;

  logic             i_clk;
  logic             i_rst;
  logic             i_mode;
  logic             i_valid;
  logic [N-1:0]     i_data;
  logic             i_last;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic [N-1:0]     o_result;
  logic [IDX_W-1:0] o_index;
  logic             o_ovf;
  logic             o_busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] tb_q[$];

  sm_minmax_stream #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_mode   (i_mode),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_index  (o_index),
    .o_ovf    (o_ovf),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed integer value of an 8-bit sign-magnitude sample.
  function automatic int sm_val(input logic [7:0] x);
    int m;
    m = int'(x[6:0]);
    return x[7] ? -m : m;
  endfunction

  task automatic run_frame(input logic mode, input int hold, input string tag);
    int n;
    int lim;
    int best;
    int guard;
    logic [7:0] exp_res;
    logic exp_ovf;
    n = tb_q.size();
    lim = (n < int'(MAX_LEN)) ? n : int'(MAX_LEN);
    best = 0;
    for (int i = 1; i < lim; i++) begin
      if ((mode == 1'b0 && sm_val(tb_q[i]) > sm_val(tb_q[best])) ||
          (mode == 1'b1 && sm_val(tb_q[i]) < sm_val(tb_q[best])))
        best = i;
    end
    exp_res = tb_q[best];
    exp_ovf = (n > int'(MAX_LEN));

    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge i_clk);
      end
      i_valid = 1'b1;
      i_data  = tb_q[i];
      i_last  = (i == n - 1);
      i_mode  = (i == 0) ? mode : 1'($urandom);
      guard = 0;
      while (!o_ready && guard < 50) begin
        @(negedge i_clk);
        guard++;
      end
      if (!o_ready) check_eq({tag, " ready_timeout"}, 32'(o_ready), 32'd1);
      @(posedge i_clk);
    end

    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    check_eq({tag, " valid_latency"}, 32'(o_valid), 32'd1);
    check_eq({tag, " result"}, 32'(o_result), 32'(exp_res));
    check_eq({tag, " index"}, 32'(o_index), 32'(best));
    check_eq({tag, " ovf"}, 32'(o_ovf), 32'(exp_ovf));
    check_eq({tag, " busy"}, 32'(o_busy), 32'd1);
    check_eq({tag, " ready_in_done"}, 32'(o_ready), 32'd0);
    repeat (hold) begin
      @(negedge i_clk);
      check_eq({tag, " hold_valid"}, 32'(o_valid), 32'd1);
      check_eq({tag, " hold_result"}, 32'(o_result), 32'(exp_res));
      check_eq({tag, " hold_index"}, 32'(o_index), 32'(best));
      check_eq({tag, " hold_ready"}, 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check_eq({tag, " valid_after_consume"}, 32'(o_valid), 32'd0);
    check_eq({tag, " ready_after_consume"}, 32'(o_ready), 32'd1);
    check_eq({tag, " busy_after_consume"}, 32'(o_busy), 32'd0);
  endtask

  function automatic logic [7:0] rand_sample();
    logic [7:0] pool [6];
    pool = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h7F, 8'hFF};
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 5)];
    return 8'($urandom);
  endfunction

  initial begin
    i_rst   = 1'b1;
    i_mode  = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check_eq("reset valid", 32'(o_valid), 32'd0);
    check_eq("reset result", 32'(o_result), 32'd0);
    check_eq("reset index", 32'(o_index), 32'd0);
    check_eq("reset ovf", 32'(o_ovf), 32'd0);
    check_eq("reset busy", 32'(o_busy), 32'd0);
    check_eq("reset ready", 32'(o_ready), 32'd1);

    tb_q = '{8'h03, 8'h85, 8'h07};
    run_frame(1'b0, 1, "max3");
    tb_q = '{8'h03, 8'h85, 8'h82, 8'h85};
    run_frame(1'b1, 0, "min_tie");
    tb_q = '{8'h80, 8'h00};
    run_frame(1'b0, 0, "zero_max");
    tb_q = '{8'h80, 8'h00};
    run_frame(1'b1, 0, "zero_min");
    tb_q = '{8'hFF};
    run_frame(1'b0, 5, "single");

    tb_q.delete();
    for (int i = 0; i < 20; i++) tb_q.push_back((i == 17) ? 8'd100 : 8'h01);
    run_frame(1'b0, 0, "ovf");

    // Abort a frame with reset after three samples.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = 8'(8'h20 + i);
      i_last  = 1'b0;
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check_eq("midrst busy", 32'(o_busy), 32'd0);
    check_eq("midrst valid", 32'(o_valid), 32'd0);
    check_eq("midrst ready", 32'(o_ready), 32'd1);
    tb_q = '{8'h10};
    run_frame(1'b0, 0, "after_rst");

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(0, 4) == 0 ? int'($urandom_range(15, 20)) : int'($urandom_range(1, 8));
      tb_q.delete();
      for (int i = 0; i < len; i++) tb_q.push_back(rand_sample());
      run_frame(1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_minmax_stream.md
Name: sm_minmax_stream

Overview:
- Sequential successor to the combinational sign-magnitude comparator.
- Consumes a framed stream of N-bit sign-magnitude samples (MSB = sign, N-1 LSBs = magnitude) over a valid/ready handshake.
- Returns the extreme sample (max or min, selectable per frame) and its index within the frame.
- Sits between sample capture and the display/report stage of the datapath.

Parameters:
- N, 8, sample width including the sign bit (N >= 2).
- MAX_LEN, 16, maximum number of frame samples that take part in the comparison (power of two, >= 2).
- IDX_W, $clog2(MAX_LEN), index width (derived; not to be overridden).

Ports:
- i_clk  input  1  clock; all logic rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_mode  input  1  0 = maximum, 1 = minimum; sampled with the first sample of a frame.
- i_valid  input  1  upstream sample valid.
- i_data  input  N  sign-magnitude sample.
- i_last  input  1  marks the final sample of a frame.
- o_ready  output  1  block accepts a sample this cycle.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_result  output  N  extreme sample, as received (not normalised).
- o_index  output  IDX_W  zero-based frame position of o_result.
- o_ovf  output  1  frame had more than MAX_LEN samples.
- o_busy  output  1  frame in progress (at least one sample accepted, result not yet delivered).

Behaviour:
- Reset values:
  - o_valid = 0, o_result = 0, o_index = 0, o_ovf = 0, o_busy = 0.
  - o_ready = 1 from the first cycle after reset.
  - FSM state = IDLE.
- Reset mid-frame or while a result is pending discards all state. No partial result is emitted.
- Handshake:
  - A sample is accepted when i_valid && o_ready.
  - A result is consumed when o_valid && i_ready.
  - o_result, o_index and o_ovf are registered and held stable while o_valid && !i_ready.
- FSM: IDLE, ACC, DONE.
  - IDLE: o_ready = 1.
    - Accepted sample without i_last: store it as the candidate, index = 0, latch i_mode, clear ovf, go to ACC.
    - Accepted sample with i_last: store as above, go directly to DONE (single-sample frame).
  - ACC: o_ready = 1; the sample counter increments on every accepted sample.
    - If count < MAX_LEN, compare the sample against the candidate.
    - Replace the candidate only if the sample is strictly greater (max mode) or strictly less (min mode).
    - Ties keep the earliest index.
    - Samples at count >= MAX_LEN are accepted but ignored for comparison, and they set the ovf flag.
    - An accepted sample with i_last moves the FSM to DONE (that sample is compared first, if in range).
  - DONE: o_ready = 0, o_valid = 1.
    - On i_ready, go to IDLE.
    - o_ready returns to 1 the following cycle; there is no same-cycle accept of the next frame.
- Latency: o_valid rises the cycle after the accepted i_last sample.
- Comparison rules (sign-magnitude):
  - +0 and -0 are equal.
  - A negative value with nonzero magnitude is less than any non-negative value.
  - Between two negatives, the larger magnitude is smaller.
  - Comparison is in magnitude width N-1, with no sign extension.
- Counter: IDX_W+1 bits, saturating at MAX_LEN; it never wraps.
- i_mode changes mid-frame have no effect.
- o_busy = 1 in ACC and DONE, and also in IDLE→DONE single-sample frames until the result is consumed.

Decomposition:
- Package sm_pkg holds:
  - typedef enum state_t {IDLE, ACC, DONE}
  - constants MODE_MAX = 1'b0, MODE_MIN = 1'b1
  - functions sm_sign(), sm_mag() and sm_is_zero(), parameterised through N
- Sub-module sm_compare (parameter N):
  - Purely combinational.
  - Outputs o_gt and o_eq for sign-magnitude operands with zero normalisation.
  - Instantiated once in the top block; min mode uses !o_gt && !o_eq.

Test Plan (N=8, MAX_LEN=16):
- Max frame 0x03(+3), 0x85(-5), 0x07(+7, last) -> o_valid one cycle after last; o_result=0x07, o_index=2, o_ovf=0.
- Min frame 0x03, 0x85, 0x82(-2), 0x85(last) -> o_result=0x85, o_index=1 (tie keeps earliest).
- Zero equality: max frame 0x80(-0), 0x00(+0, last) -> o_result=0x80, o_index=0; min mode gives the same result.
- Single sample 0xFF(-127) with i_last in IDLE -> o_result=0xFF, o_index=0. With i_ready held low for 5 cycles, outputs stay stable and o_ready=0; o_ready=1 one cycle after i_ready.
- Overflow: 20-sample max frame, +1 at positions 0–15 and +100 at position 17 -> o_result=0x01, o_index=0, o_ovf=1.
- i_rst asserted mid-frame after 3 samples -> next cycle o_busy=0, o_valid=0, o_ready=1. A new frame 0x10(last) -> o_result=0x10, o_index=0.
